// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory controller with byte lanes,
// sub-word load extension, misalignment flagging and fixed access latency.
module dmem_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] WC_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic err, err_nx;

    logic [31:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] widx;
    logic [1:0]  boff;
    logic        mis;
    logic        commit;
    logic        accept_mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] word;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] fmt;

    assign widx = addr[ADDR_W+1:2];
    assign boff = addr[1:0];

    always_comb begin
        mis = 1'b0;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr[0];
            default: mis = (boff != 2'd0);
        endcase
    end

    // Commit happens on the edge leaving IDLE (zero latency) or WAIT at count 0.
    assign commit = (state == IDLE && req && !mis && ZERO_WAIT) ||
                    (state == WAIT && cnt == 4'd0);
    assign accept_mis = (state == IDLE) && req && mis;

    always_comb begin
        be = 4'b1111;
        wd = wdata;
        case (size)
            2'd0: begin
                be = 4'b0001 << boff;
                wd = {4{wdata[7:0]}};
            end
            2'd1: begin
                be = addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata;
            end
        endcase
    end

    assign word = mem[widx];
    assign bsel = word[{boff, 3'b000} +: 8];
    assign hsel = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        fmt = word;
        case (size)
            2'd0:    fmt = {{24{~uns & bsel[7]}}, bsel};
            2'd1:    fmt = {{16{~uns & hsel[15]}}, hsel};
            default: fmt = word;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = err;
        case (state)
            IDLE: begin
                if (req) begin
                    if (mis) begin
                        state_nx = RESP;
                        err_nx   = 1'b1;
                    end else if (ZERO_WAIT) begin
                        state_nx = RESP;
                        err_nx   = 1'b0;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = WC_LOAD;
                        err_nx   = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err   <= err_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
        end else if (commit && !we) begin
            rdata <= fmt;
        end else if (accept_mis && !we) begin
            rdata <= 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign done     = (state == RESP);
    assign addr_err = done & err;
    assign stall    = req & (state != RESP) & ~rst;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller for the 5-stage pipeline's MEM stage. It replaces the fixed single-cycle, word-only data RAM hookup. It adds byte/halfword/word stores with lane enables, sign/zero-extended sub-word loads, misalignment detection, and a configurable access latency. A `stall` output freezes the pipeline until the access completes. Storage is an internal register array, so the block synthesises without IP.

## Interface
Parameters:
- `ADDR_W`, 8: word-address bits. Depth is 2^ADDR_W 32-bit words. Byte address bits [ADDR_W+1:2] select the word; higher bits are ignored, so addresses wrap.
- `WAIT_CYCLES`, 2: extra wait cycles per access, range 0..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  MEM-stage memory op valid. Held stable by the pipeline while `stall`=1.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `uns`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the operand is in the low bits.
- `rdata`  out  32  registered, formatted load result.
- `stall`  out  1  pipeline hold request.
- `done`  out  1  one-cycle pulse when the access completes.
- `addr_err`  out  1  one-cycle pulse when a misaligned access completes.

## Operation
- FSM states: IDLE, WAIT, RESP. Wait counter is 4 bits.
- IDLE:
  - `req`=0: stay in IDLE.
  - `req`=1 and misaligned: go to RESP with err flag set.
  - `req`=1, aligned, WAIT_CYCLES=0: go to RESP and commit the access.
  - Otherwise: go to WAIT, counter = WAIT_CYCLES-1.
- WAIT:
  - Counter decrements each cycle.
  - At the edge where counter = 0: commit the access and go to RESP.
- RESP: `done`=1. `addr_err`=1 if the err flag is set. Go to IDLE unconditionally at the next edge.
- Misalignment rules: half with `addr[0]`=1, or word with `addr[1:0]`≠0. A misaligned access never writes memory and produces `rdata`=0.
- Store commit: only the enabled byte lanes of word `addr[ADDR_W+1:2]` are written. Lanes are little-endian: `addr[1:0]`=0 is bits [7:0].
  - Byte: `wdata[7:0]` replicated to all lanes; enable = one-hot of `addr[1:0]`.
  - Half: `wdata[15:0]` replicated to both halves; enable = 0011 if `addr[1]`=0, else 1100.
  - Word: enable = 1111.
  - `rdata` is unchanged on a store.
- Load commit: select the byte or half lane by `addr[1:0]` / `addr[1]`. Extend to 32 bits per `uns` (ignored for words). Register the result into `rdata`.
- `stall` is combinational: `req` AND state≠RESP AND `rst`=0.
- `addr`, `we`, `size`, `uns`, `wdata` are sampled at the commit edge. They are guaranteed stable because `stall` holds the pipeline.

## Timing
- Reset values: state IDLE, counter 0, `rdata`=0, `done`=0, `addr_err`=0, `stall`=0. Memory contents are not reset.
- Aligned access: `stall` is high for WAIT_CYCLES+1 cycles starting in the cycle `req` rises. The next cycle is RESP with `stall`=0 and `done`=1, and `rdata` is valid for a load. Total occupancy is WAIT_CYCLES+2 cycles.
- Misaligned access: always one stall cycle, then RESP, regardless of WAIT_CYCLES.
- Back-to-back: the pipeline advances at the edge ending RESP. A following `req` is seen in IDLE in the next cycle, so there are no dropped or merged requests.
- `req` dropping in WAIT (flush) is a protocol error. The block still completes the access.
- Reset asserted mid-WAIT aborts the access. No write occurs and the state is IDLE immediately.
- `rdata` holds its value until the next load commit or reset.

## Test plan
- WAIT_CYCLES=2: `sw` 0xDEADBEEF to 0x10, then `lw` 0x10.
  - `stall` is high for 3 cycles per op.
  - `done` pulses in cycle 4 of each op.
  - `rdata`=0xDEADBEEF.
- Word 0x20 = 0xFFFFFFFF; `sb` 0xAA to 0x23, then `sh` 0x1234 to 0x20; `lw` 0x20 returns 0xAAFF1234.
- Word 0x30 = 0x00008081.
  - `lb` 0x30 returns 0xFFFFFF81.
  - `lbu` 0x30 returns 0x00000081.
  - `lh` 0x30 returns 0xFFFF8081.
  - `lhu` 0x32 returns 0x00000000.
- `sh` to 0x41 and `lw` from 0x42, with WAIT_CYCLES=2:
  - One stall cycle each.
  - `addr_err` and `done` pulse together.
  - Memory at 0x40 is unchanged.
  - `rdata`=0 after the load.
- `sw` 0x55 to 0x50 with `rst` pulsed during WAIT:
  - Outputs are 0 and the state is IDLE immediately.
  - A later `lw` 0x50 returns the prior contents.
- ADDR_W=8: `sw` 0xCAFE0001 to 0x404, then `lw` 0x004, returns 0xCAFE0001 (address wrap). Repeat with WAIT_CYCLES=0 to check single-cycle stall.
